// File: rtl/ddc_line_frontend.sv
// ddc_line_frontend: DDC (EDID I2C) pad front end.
// Synchronises and glitch-filters SCL/SDA, emits SCL edge and START/STOP
// strobes, tracks bus ownership, and applies the slave's SDA pull-down
// request only after a hold window that follows each SCL falling edge.
// Optional feature macro: DDC_STUCK_TIMEOUT_EN (SCL-held-low bus timeout).
module ddc_line_frontend #(
    parameter int unsigned FILT_CYCLES    = 4,
    parameter int unsigned HOLD_CYCLES    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scl_pad_i,
    input  logic sda_pad_i,
    input  logic sda_drive_i,
    output logic sda_oe_o,
    output logic scl_o,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o,
    output logic busy_o,
    output logic stuck_o
);

    localparam int unsigned FW = $clog2(FILT_CYCLES + 1);
    localparam int unsigned HW = 8;
    localparam logic [FW-1:0] FILT_LAST = FW'(FILT_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

    // Reject parameter values outside the supported ranges at elaboration.
    if (FILT_CYCLES < 1 || FILT_CYCLES > 15 || HOLD_CYCLES > 255 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("ddc_line_frontend: parameter out of range");
    end

    logic          r_scl_meta, r_scl_sync, r_sda_meta, r_sda_sync;
    logic          r_scl_f, r_sda_f;
    logic [FW-1:0] r_scl_cnt, r_sda_cnt;
    logic          r_scl_rise, r_scl_fall, r_start, r_stop, r_busy;
    logic [HW-1:0] r_hold_cnt;
    logic          r_sda_oe;

    logic          w_scl_chg, w_sda_chg;
    logic [FW-1:0] w_scl_cnt_nxt, w_sda_cnt_nxt;
    logic          w_scl_rise, w_scl_fall, w_start, w_stop;
    logic          w_to_hit, w_stuck;

    // Two-flop synchronisers; idle-high lines reset to 1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
        end else begin
            r_scl_meta <= scl_pad_i;
            r_scl_sync <= r_scl_meta;
            r_sda_meta <= sda_pad_i;
            r_sda_sync <= r_sda_meta;
        end
    end

    // Persistence filters: a new level is accepted on its FILT_CYCLES-th consecutive disagreeing cycle.
    always_comb begin
        w_scl_chg     = 1'b0;
        w_scl_cnt_nxt = '0;
        w_sda_chg     = 1'b0;
        w_sda_cnt_nxt = '0;
        if (r_scl_sync != r_scl_f) begin
            if (r_scl_cnt == FILT_LAST) w_scl_chg = 1'b1;
            else                        w_scl_cnt_nxt = r_scl_cnt + FW'(1);
        end
        if (r_sda_sync != r_sda_f) begin
            if (r_sda_cnt == FILT_LAST) w_sda_chg = 1'b1;
            else                        w_sda_cnt_nxt = r_sda_cnt + FW'(1);
        end
    end

    // Edge and bus-condition decode; an SCL change masks any START/STOP in the same cycle.
    assign w_scl_rise = w_scl_chg &  r_scl_sync;
    assign w_scl_fall = w_scl_chg & ~r_scl_sync;
    assign w_start    = w_sda_chg & ~r_sda_sync & r_scl_f & ~w_scl_chg;
    assign w_stop     = w_sda_chg &  r_sda_sync & r_scl_f & ~w_scl_chg;

`ifdef DDC_STUCK_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] r_to_cnt;
    logic          r_stuck;

    assign w_to_hit = r_busy & ~r_scl_f & ~w_scl_rise & (r_to_cnt == TO_LAST);
    assign w_stuck  = r_stuck;

    // Count SCL-low cycles while the bus is owned; latch stuck until SCL rises again.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_to_cnt <= '0;
            r_stuck  <= 1'b0;
        end else begin
            if (!r_busy || w_scl_rise)               r_to_cnt <= '0;
            else if (!r_scl_f && r_to_cnt != TO_MAX) r_to_cnt <= r_to_cnt + TW'(1);
            if (w_to_hit)        r_stuck <= 1'b1;
            else if (w_scl_rise) r_stuck <= 1'b0;
        end
    end
`else
    assign w_to_hit = 1'b0;
    assign w_stuck  = 1'b0;
`endif

    // Filtered levels, counters and registered strobes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_scl_f    <= 1'b1;
            r_sda_f    <= 1'b1;
            r_scl_cnt  <= '0;
            r_sda_cnt  <= '0;
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
        end else begin
            r_scl_cnt  <= w_scl_cnt_nxt;
            r_sda_cnt  <= w_sda_cnt_nxt;
            if (w_scl_chg) r_scl_f <= r_scl_sync;
            if (w_sda_chg) r_sda_f <= r_sda_sync;
            r_scl_rise <= w_scl_rise;
            r_scl_fall <= w_scl_fall;
            r_start    <= w_start;
            r_stop     <= w_stop;
        end
    end

    // Bus ownership follows the registered START/STOP strobes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       r_busy <= 1'b0;
        else if (w_to_hit) r_busy <= 1'b0;
        else if (r_start)  r_busy <= 1'b1;
        else if (r_stop)   r_busy <= 1'b0;
    end

    // SDA output enable is frozen while the post-fall hold counter runs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hold_cnt <= '0;
            r_sda_oe   <= 1'b0;
        end else begin
            if (w_to_hit)              r_hold_cnt <= '0;
            else if (w_scl_fall)       r_hold_cnt <= HOLD_LOAD;
            else if (r_hold_cnt != '0) r_hold_cnt <= r_hold_cnt - HW'(1);

            if (w_to_hit || w_stuck)   r_sda_oe <= 1'b0;
            else if (r_hold_cnt == '0) r_sda_oe <= sda_drive_i;
        end
    end

    assign scl_o      = r_scl_f;
    assign sda_o      = r_sda_f;
    assign scl_rise_o = r_scl_rise;
    assign scl_fall_o = r_scl_fall;
    assign start_o    = r_start;
    assign stop_o     = r_stop;
    assign busy_o     = r_busy;
    assign sda_oe_o   = r_sda_oe;
    assign stuck_o    = w_stuck;

endmodule

// File: tb/tb_ddc_line_frontend.sv
// Testbench for ddc_line_frontend: directed scenarios plus randomized pad
// activity, every cycle compared against a window-based reference model.
module tb_ddc_line_frontend;

    localparam int FILT = 4;
    localparam int HOLD = 8;
    localparam int TO   = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl_pad = 1'b1, sda_pad = 1'b1, drive = 1'b0;
    logic sda_oe, scl_o, sda_o, scl_rise, scl_fall, start_o, stop_o, busy_o, stuck_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ddc_line_frontend #(
        .FILT_CYCLES(FILT), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .scl_pad_i(scl_pad), .sda_pad_i(sda_pad),
        .sda_drive_i(drive), .sda_oe_o(sda_oe), .scl_o(scl_o), .sda_o(sda_o),
        .scl_rise_o(scl_rise), .scl_fall_o(scl_fall), .start_o(start_o),
        .stop_o(stop_o), .busy_o(busy_o), .stuck_o(stuck_o)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model state: pad history plus bus-level events by timestamp.
    bit q_scl[$];
    bit q_sda[$];
    int edge_n, last_fall, low_run;
    bit m_scl, m_sda, m_rise, m_fall, m_start, m_stop, m_busy, m_oe, m_stuck;

    function automatic bit accept(input bit q[$], input bit f);
        // Level accepted when the last FILT synchronised samples all differ from f.
        for (int i = 0; i < FILT; i++)
            if (q[q.size() - 3 - i] == f) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        q_scl.delete();
        q_sda.delete();
        for (int i = 0; i < FILT + 2; i++) begin
            q_scl.push_back(1'b1);
            q_sda.push_back(1'b1);
        end
        edge_n = 0; last_fall = -1000; low_run = 0;
        m_scl = 1; m_sda = 1; m_rise = 0; m_fall = 0; m_start = 0; m_stop = 0;
        m_busy = 0; m_oe = 0; m_stuck = 0;
    endtask

    task automatic step();
        bit sp, dp, d, ms, md, mb, mst, msp, mstk, sc, dc, rise, fall, st, so, hit, held;
        sp = scl_pad; dp = sda_pad; d = drive;
        @(posedge clk);
        edge_n++;
        q_scl.push_back(sp);
        q_sda.push_back(dp);
        if (q_scl.size() > 32) begin
            void'(q_scl.pop_front());
            void'(q_sda.pop_front());
        end
        ms = m_scl; md = m_sda; mb = m_busy; mst = m_start; msp = m_stop; mstk = m_stuck;
        sc = accept(q_scl, ms);
        dc = accept(q_sda, md);
        rise = sc && !ms;
        fall = sc && ms;
        st = dc && md && ms && !sc;
        so = dc && !md && ms && !sc;
        hit = 1'b0;
`ifdef DDC_STUCK_TIMEOUT_EN
        hit = mb && !ms && !rise && (low_run == TO - 1);
        if (!mb || rise) low_run = 0;
        else if (!ms && low_run != TO) low_run++;
        if (hit) m_stuck = 1;
        else if (rise) m_stuck = 0;
`endif
        held = (edge_n > last_fall) && (edge_n - last_fall <= HOLD);
        if (hit || mstk) m_oe = 0;
        else if (!held) m_oe = d;
        if (hit) m_busy = 0;
        else if (mst) m_busy = 1;
        else if (msp) m_busy = 0;
        if (hit) last_fall = -1000;
        else if (fall) last_fall = edge_n;
        if (sc) m_scl = !ms;
        if (dc) m_sda = !md;
        m_rise = rise; m_fall = fall; m_start = st; m_stop = so;
        #1;
        chk("scl_o", scl_o, m_scl);
        chk("sda_o", sda_o, m_sda);
        chk("scl_rise_o", scl_rise, m_rise);
        chk("scl_fall_o", scl_fall, m_fall);
        chk("start_o", start_o, m_start);
        chk("stop_o", stop_o, m_stop);
        chk("busy_o", busy_o, m_busy);
        chk("sda_oe_o", sda_oe, m_oe);
        chk("stuck_o", stuck_o, m_stuck);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int idx, cnt;
        do_reset();
        #1;
        chk("rst_scl_o", scl_o, 1);
        chk("rst_sda_o", sda_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_oe", sda_oe, 0);
        chk("rst_strobes", {scl_rise, scl_fall, start_o, stop_o}, 0);
        chk("rst_stuck", stuck_o, 0);
        run(4);

        // Short SCL glitch (3 cycles, below FILT) is ignored.
        scl_pad = 0; run(3); scl_pad = 1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin step(); if (scl_fall) cnt++; end
        chk("glitch_no_fall", cnt, 0);
        chk("glitch_scl_high", scl_o, 1);

        // 6-cycle pulse: both edges seen 2+FILT cycles after the pad.
        scl_pad = 0; idx = -1;
        for (int i = 1; i <= 6; i++) begin step(); if (scl_fall && idx < 0) idx = i; end
        chk("fall_latency", idx, 6);
        scl_pad = 1; idx = -1;
        for (int i = 1; i <= 8; i++) begin step(); if (scl_rise && idx < 0) idx = i; end
        chk("rise_latency", idx, 6);
        run(12);

        // START then STOP with SCL high.
        sda_pad = 0; idx = -1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (start_o && idx < 0) begin idx = i; step(); chk("busy_after_start", busy_o, 1); end
        end
        chk("start_latency", idx, 6);
        sda_pad = 1; idx = -1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (stop_o && idx < 0) begin idx = i; step(); chk("idle_after_stop", busy_o, 0); end
        end
        chk("stop_latency", idx, 6);
        run(4);

        // Simultaneous SCL and SDA change: only the SCL strobe.
        scl_pad = 0; sda_pad = 0;
        run(6);
        chk("simul_fall", scl_fall, 1);
        chk("simul_no_start", start_o, 0);
        run(1);
        chk("simul_busy", busy_o, 0);
        run(3);
        scl_pad = 1; sda_pad = 1;
        run(6);
        chk("simul_rise", scl_rise, 1);
        chk("simul_no_stop", stop_o, 0);
        run(15);

        // Hold window: drive rises one cycle after the SCL fall strobe.
        scl_pad = 0; idx = -1;
        for (int i = 1; i <= 8 && idx < 0; i++) begin step(); if (scl_fall) idx = i; end
        chk("hold_fall_seen", idx, 6);
        step();
        drive = 1;
        cnt = 0;
        for (int i = 0; i < 7; i++) begin step(); if (sda_oe) cnt++; end
        chk("hold_oe_frozen", cnt, 0);
        step();
        chk("hold_oe_release", sda_oe, 1);
        scl_pad = 1; run(15);

        // Asynchronous reset mid-transfer.
        sda_pad = 0; run(9);
        chk("pre_rst_busy", busy_o, 1);
        chk("pre_rst_oe", sda_oe, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy_o, 0);
        chk("arst_oe", sda_oe, 0);
        chk("arst_levels", {scl_o, sda_o}, 2'b11);
        chk("arst_strobes", {scl_rise, scl_fall, start_o, stop_o}, 0);
        sda_pad = 1; drive = 0;
        do_reset();
        run(4);

        // Randomized pad and drive activity.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(4, 0) == 0) scl_pad = ~scl_pad;
            if ($urandom_range(5, 0) == 0) sda_pad = ~sda_pad;
            if ($urandom_range(7, 0) == 0) drive = ~drive;
            step();
        end

`ifdef DDC_STUCK_TIMEOUT_EN
        // SCL held low after START: bus declared stuck, released by SCL rise.
        scl_pad = 1; sda_pad = 1; drive = 0; run(20);
        sda_pad = 0; run(9);
        chk("to_busy", busy_o, 1);
        drive = 1; scl_pad = 0;
        idx = -1;
        for (int i = 1; i <= TO + 40 && idx < 0; i++) begin step(); if (stuck_o) idx = i; end
        chk("to_stuck_seen", (idx > 0) ? 1 : 0, 1);
        chk("to_oe_forced", sda_oe, 0);
        chk("to_busy_clr", busy_o, 0);
        scl_pad = 1; idx = -1;
        for (int i = 1; i <= 10 && idx < 0; i++) begin
            step();
            if (scl_rise) begin idx = i; chk("to_stuck_clr", stuck_o, 0); end
        end
        chk("to_rise_latency", idx, 6);
        run(5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
